pipeline_ifp_stage: RTL and testbench
=====================================

Name: pipeline_ifp_stage

Overview:
Instruction Fetch Prepare stage: owns the fetch PC and sits directly upstream of the IFR (fetch-ready) stage.
- Drives pc_IFP and if_channel_sel to IFR.
- Addresses the ROM, which has a synchronous read, so data is valid to IFR in the next cycle.
- Runs a request/ready handshake with the DRAM/cache port for PCs in the DRAM region.
- Applies control-flow redirects from EX, including redirects that arrive while a DRAM fetch is in flight.

Parameters:
RESET_PC, 64'h0000_0000_0000_0000, PC value loaded on reset.
DRAM_BASE, 64'h0000_0000_8000_0000, PCs >= DRAM_BASE fetch from DRAM; lower PCs fetch from ROM.
ROM_AW, 12, ROM word-address width.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
stall  input  1  pipeline stall; PC must not advance sequentially
redirect_valid  input  1  branch/jump redirect request from EX
redirect_pc  input  64  redirect target
dram_data_ready  input  1  DRAM/cache read data valid for dram_addr
pc_IFP  output  64  current fetch PC (registered)
if_channel_sel  output  1  1 = DRAM channel, 0 = ROM channel (combinational from pc_IFP)
rom_addr  output  ROM_AW  pc_IFP[ROM_AW+1:2]
dram_addr  output  64  equals pc_IFP
dram_rd_en  output  1  DRAM read request (level)
fetch_busy  output  1  1 while in WAIT

Behaviour:
- One clock, clk. Reset is synchronous and active-high (`reset`), sampled on the clk rising edge. No other clock or reset.
- Reset state: pc_IFP = RESET_PC, state = RUN, pending_valid = 0. Combinational outputs follow from this state: dram_rd_en = 0 and fetch_busy = 0 while reset is high.
- Reset mid-WAIT: the transaction is abandoned; a late dram_data_ready is ignored in RUN unless a new request is active.
- Redirect alignment: the target is {redirect_pc[63:2], 2'b00}; the low two bits are always cleared.
- if_channel_sel = (pc_IFP >= DRAM_BASE), unsigned 64-bit compare.
- dram_rd_en = (state==RUN && if_channel_sel && !stall && !redirect_valid) || state==WAIT.
- FSM state RUN:
  - redirect_valid=1: pc_IFP <= aligned target next cycle, regardless of stall. No DRAM request this cycle. Stay in RUN.
  - else if stall: hold pc_IFP.
  - else if ROM PC: pc_IFP <= pc_IFP+4 every cycle, giving one fetch per cycle.
  - else (DRAM PC): if dram_data_ready is already 1 this cycle (zero-wait hit), pc_IFP <= pc_IFP+4 and stay in RUN. Otherwise go to WAIT with pc held.
- FSM state WAIT:
  - The transaction cannot be cancelled. pc_IFP and dram_addr stay stable; stall is ignored for holding the request.
  - redirect_valid without dram_data_ready: pending_pc <= aligned target, pending_valid <= 1. A later redirect overwrites the earlier one.
  - On dram_data_ready go to RUN and update the PC by priority:
    - redirect_valid this cycle: pc_IFP <= its aligned target.
    - else pending_valid: pc_IFP <= pending_pc.
    - else !stall: pc_IFP <= pc_IFP+4.
    - else (stall): hold pc_IFP; the next RUN cycle without stall reissues the same read (instruction reads are idempotent).
  - pending_valid clears on every exit from WAIT.
- pc+4 wraps modulo 2^64. Crossing DRAM_BASE switches the channel on the next fetch with no bubble.

Test Plan:
1. Reset high 1 cycle, then ROM run, stall=0 -> pc_IFP = 0,4,8,C on consecutive cycles; dram_rd_en = 0; rom_addr = 0,1,2,3.
2. pc_IFP = 0x8000_0000, dram_data_ready low 3 cycles then high, stall=0 -> dram_rd_en high 4 cycles, fetch_busy high 3 cycles, pc holds 0x8000_0000 then becomes 0x8000_0004.
3. In WAIT, redirect_valid 1 cycle with 0x123 and later 0x200, ready 2 cycles later -> pc_IFP = 0x200 after ready; pending_valid cleared; 0x123 is never used.
4. ROM run with stall=1 and redirect_valid with 0x8000_0010 -> pc_IFP = 0x8000_0010 next cycle; dram_rd_en = 0 that cycle; if_channel_sel = 1 afterwards.
5. In WAIT, ready arrives with stall=1 -> state RUN, pc held. Release stall -> dram_rd_en = 1 again for the same address.
6. Reset asserted during WAIT -> next cycle pc_IFP = RESET_PC, fetch_busy = 0, dram_rd_en = 0.

Source files
------------

// File: rtl/pipeline_ifp_stage.sv
// Fetch-prepare stage: owns the fetch PC and steers fetches to the ROM or DRAM channel.
// Latency: PC registered; ROM data one cycle after rom_addr; DRAM fetch waits for dram_data_ready.
// Backpressure: stall holds the PC in RUN; a DRAM fetch in flight holds the PC until dram_data_ready.
module pipeline_ifp_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
  parameter logic [63:0] DRAM_BASE = 64'h0000_0000_8000_0000,
  parameter int          ROM_AW    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  input  logic              dram_data_ready,
  output logic [63:0]       pc_IFP,
  output logic              if_channel_sel,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [63:0]       dram_addr,
  output logic              dram_rd_en,
  output logic              fetch_busy
);

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [63:0] pc_q, pc_nxt;
  logic [63:0] pending_pc, pending_pc_nxt;
  logic        pending_valid, pending_valid_nxt;
  logic [63:0] redirect_tgt;
  logic [63:0] pc_plus4;

  assign redirect_tgt = {redirect_pc[63:2], 2'b00};
  assign pc_plus4     = pc_q + 64'd4;

  assign pc_IFP         = pc_q;
  assign dram_addr      = pc_q;
  assign rom_addr       = pc_q[ROM_AW+1:2];
  assign if_channel_sel = (pc_q >= DRAM_BASE);
  // Outputs are forced quiet while reset is asserted so an abandoned DRAM fetch is not re-requested.
  assign fetch_busy     = !reset && (state == WAIT);
  assign dram_rd_en     = !reset &&
                          (((state == RUN) && if_channel_sel && !stall && !redirect_valid) ||
                           (state == WAIT));

  // State, PC and pending-redirect registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      pc_q          <= RESET_PC;
      pending_pc    <= 64'd0;
      pending_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc_q          <= pc_nxt;
      pending_pc    <= pending_pc_nxt;
      pending_valid <= pending_valid_nxt;
    end
  end

  // Next-state and next-PC selection; redirects during a DRAM fetch are parked until it completes.
  always_comb begin
    state_nxt         = state;
    pc_nxt            = pc_q;
    pending_pc_nxt    = pending_pc;
    pending_valid_nxt = pending_valid;
    case (state)
      RUN: begin
        if (redirect_valid) begin
          pc_nxt = redirect_tgt;
        end else if (stall) begin
          pc_nxt = pc_q;
        end else if (!if_channel_sel) begin
          pc_nxt = pc_plus4;
        end else if (dram_data_ready) begin
          pc_nxt = pc_plus4;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (dram_data_ready) begin
          state_nxt         = RUN;
          pending_valid_nxt = 1'b0;
          if (redirect_valid) begin
            pc_nxt = redirect_tgt;
          end else if (pending_valid) begin
            pc_nxt = pending_pc;
          end else if (!stall) begin
            pc_nxt = pc_plus4;
          end
          // With stall held, the PC stays put and the next unstalled RUN cycle re-reads it.
        end else if (redirect_valid) begin
          pending_pc_nxt    = redirect_tgt;
          pending_valid_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline_ifp_stage.sv
// Directed-vector bench for pipeline_ifp_stage.
// Latency: inputs driven on the falling edge, outputs checked 1 time unit later.
// Backpressure: stall and dram_data_ready are scripted per vector.
module tb_pipeline_ifp_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dram_data_ready;
  logic [63:0] pc_IFP;
  logic        if_channel_sel;
  logic [11:0] rom_addr;
  logic [63:0] dram_addr;
  logic        dram_rd_en;
  logic        fetch_busy;

  int errors = 0;
  int checks = 0;

  pipeline_ifp_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dram_data_ready (dram_data_ready),
    .pc_IFP          (pc_IFP),
    .if_channel_sel  (if_channel_sel),
    .rom_addr        (rom_addr),
    .dram_addr       (dram_addr),
    .dram_rd_en      (dram_rd_en),
    .fetch_busy      (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in  = {reset, stall, redirect_valid, dram_data_ready}
  // flg = {if_channel_sel, dram_rd_en, fetch_busy, pending_valid}
  typedef struct {
    logic [3:0]  in;
    logic [63:0] rpc;
    logic [63:0] pc;
    logic [11:0] rom;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] in, input logic [63:0] rpc, input logic [63:0] pc,
                     input logic [11:0] rom, input logic [3:0] flg);
    vec_t v;
    v.in = in; v.rpc = rpc; v.pc = pc; v.rom = rom; v.flg = flg;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] in, input logic [63:0] rpc);
    reset           = in[3];
    stall           = in[2];
    redirect_valid  = in[1];
    dram_data_ready = in[0];
    redirect_pc     = rpc;
  endtask

  task automatic check_all(input int row, input logic [63:0] pc, input logic [11:0] rom, input logic [3:0] flg);
    chk("pc_IFP", row, pc_IFP, pc);
    chk("dram_addr", row, dram_addr, pc);
    chk("rom_addr", row, {52'd0, rom_addr}, {52'd0, rom});
    chk("if_channel_sel", row, {63'd0, if_channel_sel}, {63'd0, flg[3]});
    chk("dram_rd_en", row, {63'd0, dram_rd_en}, {63'd0, flg[2]});
    chk("fetch_busy", row, {63'd0, fetch_busy}, {63'd0, flg[1]});
    chk("pending_valid", row, {63'd0, dut.pending_valid}, {63'd0, flg[0]});
  endtask

  initial begin
    // Reset and ROM sequential run
    add(4'b1000, 64'h0, 64'h0, 12'h000, 4'b0000);                          // 0
    add(4'b0000, 64'h0, 64'h0, 12'h000, 4'b0000);                          // 1
    add(4'b0000, 64'h0, 64'h4, 12'h001, 4'b0000);                          // 2
    add(4'b0000, 64'h0, 64'h8, 12'h002, 4'b0000);                          // 3
    add(4'b0000, 64'h0, 64'hC, 12'h003, 4'b0000);                          // 4
    // Redirect under stall into DRAM region
    add(4'b0110, 64'h8000_0010, 64'h10, 12'h004, 4'b0000);                 // 5
    add(4'b0100, 64'h0, 64'h8000_0010, 12'h004, 4'b1000);                  // 6
    // Redirect in RUN on DRAM PC suppresses request; low bits cleared
    add(4'b0010, 64'h8000_0003, 64'h8000_0010, 12'h004, 4'b1000);          // 7
    // DRAM fetch with 3 wait cycles
    add(4'b0000, 64'h0, 64'h8000_0000, 12'h000, 4'b1100);                  // 8
    add(4'b0000, 64'h0, 64'h8000_0000, 12'h000, 4'b1110);                  // 9
    add(4'b0000, 64'h0, 64'h8000_0000, 12'h000, 4'b1110);                  // 10
    add(4'b0001, 64'h0, 64'h8000_0000, 12'h000, 4'b1110);                  // 11
    // Zero-wait hit
    add(4'b0001, 64'h0, 64'h8000_0004, 12'h001, 4'b1100);                  // 12
    // Redirects during WAIT: later one wins
    add(4'b0000, 64'h0, 64'h8000_0008, 12'h002, 4'b1100);                  // 13
    add(4'b0010, 64'h123, 64'h8000_0008, 12'h002, 4'b1110);                // 14
    add(4'b0010, 64'h200, 64'h8000_0008, 12'h002, 4'b1111);                // 15
    add(4'b0000, 64'h0, 64'h8000_0008, 12'h002, 4'b1111);                  // 16
    add(4'b0001, 64'h0, 64'h8000_0008, 12'h002, 4'b1111);                  // 17
    add(4'b0100, 64'h0, 64'h200, 12'h080, 4'b0000);                        // 18
    add(4'b0010, 64'h8000_0100, 64'h200, 12'h080, 4'b0000);                // 19
    // Ready under stall: PC held, same address re-requested
    add(4'b0000, 64'h0, 64'h8000_0100, 12'h040, 4'b1100);                  // 20
    add(4'b0100, 64'h0, 64'h8000_0100, 12'h040, 4'b1110);                  // 21
    add(4'b0101, 64'h0, 64'h8000_0100, 12'h040, 4'b1110);                  // 22
    add(4'b0100, 64'h0, 64'h8000_0100, 12'h040, 4'b1000);                  // 23
    add(4'b0000, 64'h0, 64'h8000_0100, 12'h040, 4'b1100);                  // 24
    // Reset during WAIT, then a late ready is ignored
    add(4'b1000, 64'h0, 64'h8000_0100, 12'h040, 4'b1000);                  // 25
    add(4'b0101, 64'h0, 64'h0, 12'h000, 4'b0000);                          // 26
    add(4'b0001, 64'h0, 64'h0, 12'h000, 4'b0000);                          // 27
    // Wrap of pc+4 at top of address space
    add(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4, 12'h001, 4'b0000);        // 28
    add(4'b0001, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 12'hFFF, 4'b1100);        // 29
    // Crossing DRAM_BASE with no bubble
    add(4'b0010, 64'h7FFF_FFFE, 64'h0, 12'h000, 4'b0000);                  // 30
    add(4'b0000, 64'h0, 64'h7FFF_FFFC, 12'hFFF, 4'b0000);                  // 31
    add(4'b0000, 64'h0, 64'h8000_0000, 12'h000, 4'b1100);                  // 32
    add(4'b0001, 64'h0, 64'h8000_0000, 12'h000, 4'b1110);                  // 33
    add(4'b0100, 64'h0, 64'h8000_0004, 12'h001, 4'b1000);                  // 34

    drive(4'b1000, 64'h0);
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].in, vecs[i].rpc);
      #1;
      check_all(i, vecs[i].pc, vecs[i].rom, vecs[i].flg);
      @(negedge clk);
    end

    // Redirect arriving together with ready overrides a parked redirect.
    drive(4'b0000, 64'h0);
    #1;
    chk("seq_rd_en_issue", 100, {63'd0, dram_rd_en}, 64'd1);
    @(negedge clk);
    drive(4'b0010, 64'h8000_0040);
    #1;
    chk("seq_busy", 101, {63'd0, fetch_busy}, 64'd1);
    @(negedge clk);
    drive(4'b0011, 64'h45);
    #1;
    chk("seq_pending_set", 102, {63'd0, dut.pending_valid}, 64'd1);
    @(negedge clk);
    drive(4'b0100, 64'h0);
    #1;
    check_all(103, 64'h44, 12'h011, 4'b0000);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
